// File: rtl/div_unit_pkg.sv
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared encodings and helpers for the EX-stage divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // MDU operation encodings, sitting beside the ALUOp encodings
    localparam logic [1:0] MDUOp_div  = 2'b00;
    localparam logic [1:0] MDUOp_divu = 2'b01;
    localparam logic [1:0] MDUOp_rem  = 2'b10;
    localparam logic [1:0] MDUOp_remu = 2'b11;

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divide/remainder unit (EX stage).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [WIDTH-1:0] dvs_q,     dvs_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] c_q,       c_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] result;

    // One restoring step; diff[WIDTH] set means the trial subtraction borrowed
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        if (mdu_is_rem(op_q)) begin
            result = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
        end else begin
            result = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
        end
    end

    assign a_neg = mdu_is_signed(op) & A[WIDTH-1];
    assign b_neg = mdu_is_signed(op) & B[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        c_d       = c_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (B == '0) begin
                        c_d     = mdu_is_rem(op) ? A : C_ALL_ONES;
                        state_d = ST_DONE;
                    end else if (mdu_is_signed(op) && A == C_MOST_NEG && B == C_ALL_ONES) begin
                        c_d     = mdu_is_rem(op) ? '0 : C_MOST_NEG;
                        state_d = ST_DONE;
                    end else begin
                        quo_d   = a_neg ? (~A + 1'b1) : A;
                        dvs_d   = b_neg ? (~B + 1'b1) : B;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_STEP) begin
                        c_d     = result;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            c_q       <= c_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign C    = c_q;

endmodule

`default_nettype wire
